piso_bit_serializer: RTL and testbench
======================================

// Module: piso_bit_serializer
// PURPOSE
//  Upstream feeder for the serial sequence-detector FSMs (e.g. the "101" Mealy detector).
//  Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock.
//  The serial bit drives the detector's single-bit 'in'. Optional idle gap between words.
//  Holds a defined idle level when not shifting, so the detector never sees X.
// PARAMETERS
//  WIDTH       8   bits per word; legal range >= 2
//  MSB_FIRST   1   1: din[WIDTH-1] goes out first; 0: din[0] goes out first
//  IDLE_BIT    0   level driven on sout when sout_valid=0
//  GAP_CYCLES  0   idle cycles inserted after each word; 0 means back-to-back words
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous, active-high reset
//  din         in   WIDTH  parallel word
//  din_valid   in   1      din is valid
//  din_ready   out  1      serializer can accept din this cycle
//  sout        out  1      serial bit; connects to the detector's 'in'
//  sout_valid  out  1      sout carries a data bit this cycle
//  word_done   out  1      1-cycle pulse, coincident with the last bit of a word
//  busy        out  1      state != IDLE
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): state=IDLE; sout=IDLE_BIT; sout_valid=0; word_done=0.
//    Bit/gap counters and shift register are cleared. din_ready=0 while rst=1.
//  - States:
//    IDLE: din_ready=1. On the accepting edge (din_valid & din_ready):
//      load shift reg, bit_cnt=0, go to SHIFT.
//    SHIFT: shift one bit per clk; bit_cnt increments. Leave after bit_cnt==WIDTH-1:
//      if GAP_CYCLES>0, go to GAP with gap_cnt=0;
//      else if a new word is accepted on that edge, stay in SHIFT and reload;
//      else go to IDLE.
//    GAP: sout=IDLE_BIT; sout_valid=0; din_ready=0. After GAP_CYCLES cycles, go to IDLE.
//  - Timing. Accepting edge = E0.
//    - First bit is registered on E0 and shown on sout with sout_valid=1 during E0..E1.
//    - Bit k is shown after edge Ek; the last bit is shown after E(WIDTH-1).
//    - word_done=1 only in the last-bit cycle.
//  - din_ready = (state==IDLE) | (state==SHIFT & bit_cnt==WIDTH-1 & GAP_CYCLES==0), and 0 during rst.
//    - Combinational from registered state only; no din_valid->din_ready path.
//    - With GAP_CYCLES==0, back-to-back words give a continuous stream with no bubble.
//  - din_valid while din_ready=0: ignored. Source must hold din/din_valid until accepted.
//  - sout, sout_valid and word_done are registered outputs. busy is decoded from state.
//  - Widths:
//    - bit_cnt is $clog2(WIDTH) bits and never wraps past WIDTH-1.
//    - gap_cnt is $clog2(GAP_CYCLES+1) bits. With GAP_CYCLES==0, GAP is unreachable.
//  - Reset mid-word: the partial word is dropped with no word_done. Next cycle shows idle outputs.
//  - Illegal or unused state encoding: go to IDLE with idle outputs on the next edge.
// STRUCTURE
//  - Shared package ser_pkg: state encoding IDLE=2'b00, SHIFT=2'b01, GAP=2'b10 (2-bit typedef).
//  - Same package: localparam helpers for counter widths.
//  - Single module; no sub-module needed (one shift reg, two counters, 3-state FSM).
//  - Next-state/output logic in one combinational block; registers in one clocked block.
// TESTING
//  1 Reset: hold rst 3 cycles mid-stream.
//    -> sout=0, sout_valid=0, word_done=0, busy=0 after first rst edge.
//    -> din_ready=1 the cycle after rst drops.
//  2 Single word: WIDTH=8, MSB_FIRST=1, din=8'hA0, pulse din_valid.
//    -> sout = 1,0,1,0,0,0,0,0 on consecutive cycles; word_done only on the 8th bit.
//    -> Chained detector 'out' pulses once, on the 3rd bit.
//  3 Back-to-back: GAP_CYCLES=0, din_valid held high with words 8'hFF, 8'h00.
//    -> 16 contiguous sout_valid cycles; din_ready high only in cycle 8 (and in IDLE).
//  4 LSB-first + gap: MSB_FIRST=0, GAP_CYCLES=3, din=8'h05, then din=8'h01 pending.
//    -> sout = 1,0,1,0,0,0,0,0; then 3 cycles of sout_valid=0, sout=IDLE_BIT.
//    -> Second word accepted in the following IDLE cycle.
//  5 Abort: rst asserted after 4 bits of 8'hB6.
//    -> No word_done; sout_valid=0 next cycle; a fresh word then serializes fully.
//  6 Stalled source: din_valid toggled while busy.
//    -> No acceptance outside ready cycles; word count in == word_done count.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared definitions for the parallel-in / serial-out bit serializer.
package ser_pkg;

  // State encoding is fixed so that an unused code (2'b11) is easy to spot.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10
  } ser_state_t;

  // Counter width able to hold values 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int SER_WIDTH_DEF = 8;
  localparam int SER_GAP_DEF   = 0;

endpackage

// File: rtl/piso_bit_serializer.sv
// Parallel-in / serial-out bit serializer feeding single-bit sequence detectors.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no word in flight; din_ready=1, sout held at IDLE_BIT
//   SHIFT | one data bit per clock on sout; bit_cnt = index of bit on sout
//   GAP   | post-word idle gap of GAP_CYCLES clocks; din_ready=0
//
// A word is accepted on the edge where din_valid & din_ready; bit 0 of the
// output order is registered on that same edge. With no gap, a new word can
// be accepted on the edge that retires the last bit, giving a bubble-free
// stream.
module piso_bit_serializer
  import ser_pkg::*;
#(
  parameter int   WIDTH      = SER_WIDTH_DEF,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_BIT   = 1'b0,
  parameter int   GAP_CYCLES = SER_GAP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int BW = cnt_w(WIDTH);
  localparam int GW = cnt_w(GAP_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  ser_state_t       state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n, bit_inc;
  logic [GW-1:0]    gap_cnt, gap_cnt_n;
  logic             sout_n, sout_valid_n, word_done_n;
  logic             accept;

  // Ready depends only on registered state (plus reset), never on din_valid.
  assign din_ready = !rst && ((state == IDLE) ||
                              ((state == SHIFT) && (bit_cnt == BIT_LAST) && (GAP_CYCLES == 0)));
  assign busy      = (state != IDLE);
  assign accept    = din_valid && din_ready;
  assign bit_inc   = bit_cnt + 1'b1;

  // Next-state, next-shift-register and next-output decode.
  always_comb begin
    state_n      = IDLE;
    shreg_n      = shreg;
    bit_cnt_n    = '0;
    gap_cnt_n    = '0;
    sout_n       = IDLE_BIT;
    sout_valid_n = 1'b0;
    word_done_n  = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          state_n      = SHIFT;
          sout_valid_n = 1'b1;
          sout_n       = MSB_FIRST ? din[WIDTH-1] : din[0];
          shreg_n      = MSB_FIRST ? (din << 1) : (din >> 1);
        end
      end

      SHIFT: begin
        if (bit_cnt != BIT_LAST) begin
          state_n      = SHIFT;
          bit_cnt_n    = bit_inc;
          sout_valid_n = 1'b1;
          sout_n       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
          shreg_n      = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
          word_done_n  = (bit_inc == BIT_LAST);
        end else if (GAP_CYCLES > 0) begin
          state_n = GAP;
        end else if (accept) begin
          state_n      = SHIFT;
          sout_valid_n = 1'b1;
          sout_n       = MSB_FIRST ? din[WIDTH-1] : din[0];
          shreg_n      = MSB_FIRST ? (din << 1) : (din >> 1);
        end
      end

      GAP: begin
        if (gap_cnt != GAP_LAST) begin
          state_n   = GAP;
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      sout       <= IDLE_BIT;
      sout_valid <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      gap_cnt    <= gap_cnt_n;
      sout       <= sout_n;
      sout_valid <= sout_valid_n;
      word_done  <= word_done_n;
    end
  end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Scoreboard bench for piso_bit_serializer.
// Lane a: WIDTH=8, MSB first, no gap.  Lane b: WIDTH=8, LSB first, 3-cycle gap.
module tb_piso_bit_serializer;

  typedef struct packed {
    logic b;
    logic wd;
    logic f;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // lane a
  logic       a_rst = 1'b1;
  logic [7:0] a_din = 8'h00;
  logic       a_din_valid = 1'b0;
  logic       a_din_ready, a_sout, a_sout_valid, a_word_done, a_busy;
  // lane b
  logic       b_rst = 1'b1;
  logic [7:0] b_din = 8'h00;
  logic       b_din_valid = 1'b0;
  logic       b_din_ready, b_sout, b_sout_valid, b_word_done, b_busy;

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .rst(a_rst), .din(a_din), .din_valid(a_din_valid), .din_ready(a_din_ready),
    .sout(a_sout), .sout_valid(a_sout_valid), .word_done(a_word_done), .busy(a_busy)
  );

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .GAP_CYCLES(3)) dut_b (
    .clk(clk), .rst(b_rst), .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
    .sout(b_sout), .sout_valid(b_sout_valid), .word_done(b_word_done), .busy(b_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected serial order of the word currently driven, first bit at [7].
  logic [7:0] a_exp = 8'h00;
  logic [7:0] b_exp = 8'h00;
  exp_t a_q[$];
  exp_t b_q[$];
  logic a_accp = 1'b0, b_accp = 1'b0;
  logic a_rstq = 1'b1, b_rstq = 1'b1;
  int a_words = 0, a_done = 0, a_aborted = 0;
  int b_words = 0, b_done = 0;
  int b_cyc = 0, b_last_done_cyc = -1000, b_gap = 0;
  int det_st = 0, det_idx = 0, det_pulses = 0, det_pos = -1;
  logic det_en = 1'b0;

  always @(posedge clk) begin
    a_rstq <= a_rst;
    b_rstq <= b_rst;
  end

  // Acceptance is sampled at the falling edge; inputs are stable until the next rising edge.
  always @(negedge clk) begin
    a_accp = a_din_valid && a_din_ready && !a_rst;
    b_accp = b_din_valid && b_din_ready && !b_rst;
  end

  // Push the expected serial bits on the accepting edge.
  always @(posedge clk) begin
    if (a_accp) begin
      for (int k = 0; k < 8; k++) a_q.push_back('{b: a_exp[7-k], wd: (k == 7), f: (k == 0)});
      a_words++;
    end
    if (b_accp) begin
      for (int k = 0; k < 8; k++) b_q.push_back('{b: b_exp[7-k], wd: (k == 7), f: (k == 0)});
      b_words++;
    end
  end

  // Lane a monitor.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_rstq) begin
      a_q.delete();
      chk("a_rst_idle", 32'({a_sout, a_sout_valid, a_word_done, a_busy}), 32'h0);
    end else if (a_q.size() > 0) begin
      e = a_q.pop_front();
      chk("a_valid", 32'(a_sout_valid), 32'h1);
      chk("a_bit", 32'(a_sout), 32'(e.b));
      chk("a_word_done", 32'(a_word_done), 32'(e.wd));
      chk("a_ready", 32'(a_din_ready), 32'(e.wd && !a_rst));
      if (a_word_done) a_done++;
      if (det_en) begin
        if (det_st == 2 && a_sout) begin
          det_pulses++;
          det_pos = det_idx;
        end
        det_st = a_sout ? 1 : ((det_st == 1) ? 2 : 0);
        det_idx++;
      end
    end else begin
      chk("a_idle", 32'({a_sout, a_sout_valid, a_word_done}), 32'h0);
    end
  end

  // Lane b monitor.
  always @(negedge clk) begin : mon_b
    exp_t e;
    b_cyc++;
    if (b_rstq) begin
      b_q.delete();
      chk("b_rst_idle", 32'({b_sout, b_sout_valid, b_word_done, b_busy}), 32'h0);
    end else if (b_q.size() > 0) begin
      e = b_q.pop_front();
      chk("b_valid", 32'(b_sout_valid), 32'h1);
      chk("b_bit", 32'(b_sout), 32'(e.b));
      chk("b_word_done", 32'(b_word_done), 32'(e.wd));
      chk("b_ready", 32'(b_din_ready), 32'h0);
      if (b_word_done) b_done++;
      if (e.f) b_gap = b_cyc - b_last_done_cyc;
      if (e.wd) b_last_done_cyc = b_cyc;
    end else begin
      chk("b_idle", 32'({b_sout, b_sout_valid, b_word_done}), 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drives a word and returns just after the accepting edge with din_valid still high.
  task automatic send_a(input logic [7:0] d, input logic [7:0] seq);
    logic ok;
    ok = 1'b0;
    a_din = d;
    a_exp = seq;
    a_din_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_din_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("a_accept_timeout", 32'h0, 32'h1);
    tick();
  endtask

  task automatic send_b(input logic [7:0] d, input logic [7:0] seq);
    logic ok;
    ok = 1'b0;
    b_din = d;
    b_exp = seq;
    b_din_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b_din_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("b_accept_timeout", 32'h0, 32'h1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // power-up reset on both lanes
    ticks(3);
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(negedge clk);
    chk("a_ready_after_rst", 32'(a_din_ready), 32'h1);
    chk("b_ready_after_rst", 32'(b_din_ready), 32'h1);
    tick();

    // reset held 3 cycles in the middle of a word
    send_a(8'h96, 8'h96);
    a_din_valid = 1'b0;
    ticks(2);
    a_rst = 1'b1;
    @(negedge clk);
    chk("a_ready_in_rst", 32'(a_din_ready), 32'h0);
    ticks(3);
    a_rst = 1'b0;
    a_aborted++;
    @(negedge clk);
    chk("a_ready_after_rst2", 32'(a_din_ready), 32'h1);
    tick();

    // single word 8'hA0 into a "101" detector
    det_st = 0;
    det_idx = 0;
    det_pulses = 0;
    det_pos = -1;
    det_en = 1'b1;
    send_a(8'hA0, 8'hA0);
    a_din_valid = 1'b0;
    ticks(10);
    det_en = 1'b0;
    chk("det_pulses", 32'(det_pulses), 32'd1);
    chk("det_pos", 32'(det_pos), 32'd2);

    // back-to-back words with din_valid held
    send_a(8'hFF, 8'hFF);
    send_a(8'h00, 8'h00);
    a_din_valid = 1'b0;
    ticks(10);

    // LSB first with gap; second word pending during the gap
    send_b(8'h05, 8'hA0);
    send_b(8'h01, 8'h80);
    b_din_valid = 1'b0;
    ticks(20);
    chk("b_gap_to_next_word", 32'(b_gap), 32'd5);

    // abort after 4 bits of 8'hB6, then a fresh word
    send_a(8'hB6, 8'hB6);
    a_din_valid = 1'b0;
    ticks(3);
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    a_aborted++;
    tick();
    send_a(8'h3C, 8'h3C);
    a_din_valid = 1'b0;
    ticks(10);

    // source toggling din_valid while busy
    send_a(8'h5A, 8'h5A);
    for (int i = 0; i < 24; i++) begin
      a_din = 8'hC3;
      a_exp = 8'hC3;
      a_din_valid = (i % 3 != 2);
      tick();
    end
    a_din_valid = 1'b0;
    b_din = 8'h6D;
    b_exp = 8'hB6;
    for (int i = 0; i < 30; i++) begin
      b_din_valid = (i % 4 != 3);
      tick();
    end
    b_din_valid = 1'b0;
    ticks(30);

    chk("a_queue_empty", 32'(a_q.size()), 32'd0);
    chk("b_queue_empty", 32'(b_q.size()), 32'd0);
    chk("a_words_vs_done", 32'(a_done), 32'(a_words - a_aborted));
    chk("b_words_vs_done", 32'(b_done), 32'(b_words));
    chk("a_min_words", 32'(a_words >= 9), 32'h1);
    chk("b_min_words", 32'(b_words >= 3), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
